if_pc_unit: RTL and testbench
=============================

// Module: if_pc_unit
// PURPOSE
//  Fetch-stage program-counter unit: holds the PC register and selects the next PC
//  from sequential (PC+INC), ID branch, EX jump/mispredict and exception-vector sources
//  by fixed priority. Stores a redirect that arrives during a stall and applies it on
//  release. Drives the IF/ID PC/valid pipeline register. Sits between the hazard unit
//  and instruction memory. Parametrised successor to the 2:1 fetch next-PC mux.
// PARAMETERS
//  PC_W      16      PC/address width in bits
//  INC       1       sequential increment (word-addressed memory)
//  RESET_PC  0       PC value loaded on reset
//  EXC_VEC   16'hFF00  exception vector address, PC_W bits
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     asynchronous reset, active-high
//  stall_i       in   1     hazard stall: hold PC and IF/ID
//  id_redir_i    in   1     ID branch taken
//  id_target_i   in   PC_W  ID branch target
//  ex_redir_i    in   1     EX jump/mispredict redirect
//  ex_target_i   in   PC_W  EX redirect target
//  exc_i         in   1     exception request (target EXC_VEC)
//  pc_o          out  PC_W  current fetch address to instruction memory
//  ifid_pc_o     out  PC_W  PC of instruction in IF/ID
//  ifid_pcinc_o  out  PC_W  that PC + INC, for link/branch arithmetic
//  ifid_valid_o  out  1     IF/ID holds a real instruction (0 = bubble)
//  redir_pend_o  out  1     a stored redirect awaits stall release
// BEHAVIOUR
//  - Reset (async, immediate): pc_o=RESET_PC; ifid_pc_o=0; ifid_pcinc_o=0; ifid_valid_o=0;
//    pending register cleared, redir_pend_o=0. First fetch at RESET_PC in cycle 1 after rst falls.
//  - Priority levels: EXC=3 > EX=2 > ID=1 > SEQ=0. Live request = highest asserted input.
//  - Not stalled: next PC = target of max(live, pending) by level; on a tie, live wins.
//    Pending cleared the same edge. Latency of a redirect: 1 cycle (pc_o = target next cycle).
//  - Stalled: pc_o holds. A live request at level >= stored level overwrites pending
//    (target + level); lower-level requests are dropped. redir_pend_o is 1 from the
//    cycle after capture until the edge that applies it.
//  - IF/ID register, not stalled: ifid_pc_o<=pc_o, ifid_pcinc_o<=pc_o+INC,
//    ifid_valid_o<=1, except ifid_valid_o<=0 when any redirect (live or pending) is applied.
//  - IF/ID under stall: holds, except ex_redir_i or exc_i forces ifid_valid_o<=0 (flush
//    beats stall); id_redir_i under stall does not flush IF/ID.
//  - Arithmetic: PC+INC modulo 2^PC_W; PC=2^PC_W-1, INC=1 wraps to 0, no flag.
//  - Targets are used verbatim; no alignment check.
//  - Reset mid-stall or with pending redirect: pending discarded, restart at RESET_PC.
// STRUCTURE
//  - Shared header pipe_defs.vh: level constants LVL_SEQ/LVL_ID/LVL_EX/LVL_EXC (2 bits),
//    default PC_W, RESET_PC, EXC_VEC.
//  - One combinational sub-module pc_prio_sel: inputs 3 requests + targets + pending
//    level/target, outputs selected target, level, redirect flag. Registers stay in
//    if_pc_unit.
// TESTING
//  1 rst 3 cycles, release, no requests -> pc_o 0,1,2,3; ifid_valid_o 0 then 1 from cycle 2.
//  2 pc_o=0x0010, id_redir_i=1 target 0x0040 -> next pc_o=0x0040, ifid_valid_o=0 that cycle.
//  3 same cycle id(0x0040)+ex(0x0080)+exc -> pc_o=EXC_VEC 0xFF00; ex+id only -> 0x0080.
//  4 stall_i=1, id_redir 0x0040 then ex_redir 0x0080 two cycles later, stall 2 more cycles
//    -> pc_o held, redir_pend_o=1, ifid_valid_o=0 after ex; on release pc_o=0x0080, pend 0.
//  5 RESET_PC=16'hFFFF, INC=1 -> pc_o FFFF, 0000, 0001; ifid_pcinc_o for FFFF = 0000.
//  6 pending redirect under stall, assert rst mid-cycle -> outputs reset immediately,
//    pc_o=RESET_PC after release, redir_pend_o=0.

Source files
------------

// File: rtl/if_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: redirect priority levels and default geometry.
package if_pc_unit_pkg;
   localparam logic [1:0] LVL_SEQ = 2'd0;
   localparam logic [1:0] LVL_ID  = 2'd1;
   localparam logic [1:0] LVL_EX  = 2'd2;
   localparam logic [1:0] LVL_EXC = 2'd3;

   localparam int          PC_W_DEF     = 16;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;
   localparam logic [15:0] EXC_VEC_DEF  = 16'hFF00;
endpackage

// File: rtl/if_pc_unit_prio_sel.sv
// Combinational next-PC source selection: highest live request versus the stored
// pending redirect; on equal level the live request wins.
module pc_prio_sel
   import if_pc_unit_pkg::*;
#(
   parameter int              PC_W    = PC_W_DEF,
   parameter logic [PC_W-1:0] EXC_VEC = PC_W'(EXC_VEC_DEF)
) (
   input  logic            id_redir,
   input  logic [PC_W-1:0] id_target,
   input  logic            ex_redir,
   input  logic [PC_W-1:0] ex_target,
   input  logic            exc,
   input  logic            pend_vld,
   input  logic [1:0]      pend_lvl,
   input  logic [PC_W-1:0] pend_tgt,
   output logic [PC_W-1:0] sel_tgt,
   output logic [1:0]      sel_lvl,
   output logic            redir
);
   logic [1:0]      live_lvl;
   logic [PC_W-1:0] live_tgt;

   always_comb begin
      live_lvl = LVL_SEQ;
      live_tgt = '0;
      if (exc) begin
         live_lvl = LVL_EXC;
         live_tgt = EXC_VEC;
      end else if (ex_redir) begin
         live_lvl = LVL_EX;
         live_tgt = ex_target;
      end else if (id_redir) begin
         live_lvl = LVL_ID;
         live_tgt = id_target;
      end
   end

   always_comb begin
      sel_lvl = live_lvl;
      sel_tgt = live_tgt;
      if (pend_vld && (pend_lvl > live_lvl)) begin
         sel_lvl = pend_lvl;
         sel_tgt = pend_tgt;
      end
      redir = (sel_lvl != LVL_SEQ);
   end
endmodule

// File: rtl/if_pc_unit.sv
// Fetch-stage PC register, stall-time redirect capture and IF/ID PC/valid register.
// Redirects take effect one cycle after being applied; a redirect seen under stall is held until release.
module if_pc_unit
   import if_pc_unit_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] INC      = PC_W'(1),
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
   parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(EXC_VEC_DEF)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   input  logic            id_redir_i,
   input  logic [PC_W-1:0] id_target_i,
   input  logic            ex_redir_i,
   input  logic [PC_W-1:0] ex_target_i,
   input  logic            exc_i,
   output logic [PC_W-1:0] pc_o,
   output logic [PC_W-1:0] ifid_pc_o,
   output logic [PC_W-1:0] ifid_pcinc_o,
   output logic            ifid_valid_o,
   output logic            redir_pend_o
);
   logic            pend_vld;
   logic [1:0]      pend_lvl;
   logic [PC_W-1:0] pend_tgt;
   logic [PC_W-1:0] sel_tgt;
   logic [1:0]      sel_lvl;
   logic            redir;
   logic [PC_W-1:0] pc_inc;

   assign pc_inc       = pc_o + INC;
   assign redir_pend_o = pend_vld;

   pc_prio_sel #(
      .PC_W    (PC_W),
      .EXC_VEC (EXC_VEC)
   ) u_sel (
      .id_redir  (id_redir_i),
      .id_target (id_target_i),
      .ex_redir  (ex_redir_i),
      .ex_target (ex_target_i),
      .exc       (exc_i),
      .pend_vld  (pend_vld),
      .pend_lvl  (pend_lvl),
      .pend_tgt  (pend_tgt),
      .sel_tgt   (sel_tgt),
      .sel_lvl   (sel_lvl),
      .redir     (redir)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_o         <= RESET_PC;
         ifid_pc_o    <= '0;
         ifid_pcinc_o <= '0;
         ifid_valid_o <= 1'b0;
         pend_vld     <= 1'b0;
         pend_lvl     <= LVL_SEQ;
         pend_tgt     <= '0;
      end else if (stall_i) begin
         // The selector already resolves live-vs-pending priority, so re-storing its
         // choice both captures a stronger request and keeps the old one otherwise.
         if (redir) begin
            pend_vld <= 1'b1;
            pend_lvl <= sel_lvl;
            pend_tgt <= sel_tgt;
         end
         if (ex_redir_i || exc_i)
            ifid_valid_o <= 1'b0;
      end else begin
         pc_o         <= redir ? sel_tgt : pc_inc;
         ifid_pc_o    <= pc_o;
         ifid_pcinc_o <= pc_inc;
         ifid_valid_o <= ~redir;
         pend_vld     <= 1'b0;
         pend_lvl     <= LVL_SEQ;
      end
   end
endmodule

// File: tb/tb_if_pc_unit.sv
// Directed bench for if_pc_unit: expectations queued per step, checked after each edge.
module tb_if_pc_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_b = 1'b1;
   logic        stall_i = 1'b0;
   logic        id_redir_i = 1'b0;
   logic [15:0] id_target_i = '0;
   logic        ex_redir_i = 1'b0;
   logic [15:0] ex_target_i = '0;
   logic        exc_i = 1'b0;
   logic        zero1 = 1'b0;
   logic [15:0] zero16 = '0;

   logic [15:0] pc_o, ifid_pc_o, ifid_pcinc_o;
   logic        ifid_valid_o, redir_pend_o;
   logic [15:0] pc_b, ifid_pc_b, ifid_pcinc_b;
   logic        ifid_valid_b, redir_pend_b;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      bit          dut_b;
      logic [15:0] pc;
      logic [15:0] ipc;
      logic [15:0] inc;
      logic        v;
      logic        p;
   } exp_t;

   exp_t sb[$];
   int   step_no = 0;

   always #5 clk = ~clk;

   if_pc_unit u_dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .id_redir_i   (id_redir_i),
      .id_target_i  (id_target_i),
      .ex_redir_i   (ex_redir_i),
      .ex_target_i  (ex_target_i),
      .exc_i        (exc_i),
      .pc_o         (pc_o),
      .ifid_pc_o    (ifid_pc_o),
      .ifid_pcinc_o (ifid_pcinc_o),
      .ifid_valid_o (ifid_valid_o),
      .redir_pend_o (redir_pend_o)
   );

   if_pc_unit #(.RESET_PC(16'hFFFF)) u_dut_b (
      .clk          (clk),
      .rst          (rst_b),
      .stall_i      (zero1),
      .id_redir_i   (zero1),
      .id_target_i  (zero16),
      .ex_redir_i   (zero1),
      .ex_target_i  (zero16),
      .exc_i        (zero1),
      .pc_o         (pc_b),
      .ifid_pc_o    (ifid_pc_b),
      .ifid_pcinc_o (ifid_pcinc_b),
      .ifid_valid_o (ifid_valid_b),
      .redir_pend_o (redir_pend_b)
   );

   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL step%0d %s observed=%h expected=%h", step_no, tag, obs, exp);
      end
   endtask

   task automatic expect_state(input bit b, input logic [15:0] pc, input logic [15:0] ipc,
                               input logic [15:0] inc, input logic v, input logic p);
      exp_t e;
      e.dut_b = b; e.pc = pc; e.ipc = ipc; e.inc = inc; e.v = v; e.p = p;
      sb.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      step_no++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL step%0d scoreboard_empty observed=0 expected=1", step_no);
      end else begin
         e = sb.pop_front();
         if (e.dut_b) begin
            cmp("b_pc",    pc_b,                  e.pc);
            cmp("b_ifid",  ifid_pc_b,             e.ipc);
            cmp("b_inc",   ifid_pcinc_b,          e.inc);
            cmp("b_valid", {15'd0, ifid_valid_b}, {15'd0, e.v});
            cmp("b_pend",  {15'd0, redir_pend_b}, {15'd0, e.p});
         end else begin
            cmp("pc",    pc_o,                  e.pc);
            cmp("ifid",  ifid_pc_o,             e.ipc);
            cmp("inc",   ifid_pcinc_o,          e.inc);
            cmp("valid", {15'd0, ifid_valid_o}, {15'd0, e.v});
            cmp("pend",  {15'd0, redir_pend_o}, {15'd0, e.p});
         end
      end
   endtask

   task automatic drive(input logic s, input logic id, input logic [15:0] idt,
                        input logic ex, input logic [15:0] ext, input logic ex_c);
      stall_i = s; id_redir_i = id; id_target_i = idt;
      ex_redir_i = ex; ex_target_i = ext; exc_i = ex_c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_now();
   endtask

   initial begin
      // Reset held for three cycles
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      expect_state(0, 16'h0000, 16'h0000, 16'h0000, 0, 0); check_now();
      rst = 1'b0;
      expect_state(0, 16'h0000, 16'h0000, 16'h0000, 0, 0); check_now();

      // Sequential fetch
      expect_state(0, 16'h0001, 16'h0000, 16'h0001, 1, 0); tick();
      expect_state(0, 16'h0002, 16'h0001, 16'h0002, 1, 0); tick();
      expect_state(0, 16'h0003, 16'h0002, 16'h0003, 1, 0); tick();

      // EX redirect to 0x0010, then ID branch to 0x0040
      drive(0, 0, 0, 1, 16'h0010, 0);
      expect_state(0, 16'h0010, 16'h0003, 16'h0004, 0, 0); tick();
      drive(0, 1, 16'h0040, 0, 0, 0);
      expect_state(0, 16'h0040, 16'h0010, 16'h0011, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0);
      expect_state(0, 16'h0041, 16'h0040, 16'h0041, 1, 0); tick();

      // Priority: all three live, then EX+ID
      drive(0, 1, 16'h0040, 1, 16'h0080, 1);
      expect_state(0, 16'hFF00, 16'h0041, 16'h0042, 0, 0); tick();
      drive(0, 1, 16'h0040, 1, 16'h0080, 0);
      expect_state(0, 16'h0080, 16'hFF00, 16'hFF01, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0);
      expect_state(0, 16'h0081, 16'h0080, 16'h0081, 1, 0); tick();

      // Stall: ID captured (no flush), EX overwrites two cycles later and flushes
      drive(1, 1, 16'h0040, 0, 0, 0);
      expect_state(0, 16'h0081, 16'h0080, 16'h0081, 1, 1); tick();
      drive(1, 0, 0, 0, 0, 0);
      expect_state(0, 16'h0081, 16'h0080, 16'h0081, 1, 1); tick();
      drive(1, 0, 0, 1, 16'h0080, 0);
      expect_state(0, 16'h0081, 16'h0080, 16'h0081, 0, 1); tick();
      drive(1, 0, 0, 0, 0, 0);
      expect_state(0, 16'h0081, 16'h0080, 16'h0081, 0, 1); tick();
      expect_state(0, 16'h0081, 16'h0080, 16'h0081, 0, 1); tick();
      drive(0, 0, 0, 0, 0, 0);
      expect_state(0, 16'h0080, 16'h0081, 16'h0082, 0, 0); tick();
      expect_state(0, 16'h0081, 16'h0080, 16'h0081, 1, 0); tick();

      // Lower-level request under stall is dropped
      drive(1, 0, 0, 1, 16'h0200, 0);
      expect_state(0, 16'h0081, 16'h0080, 16'h0081, 0, 1); tick();
      drive(1, 1, 16'h0300, 0, 0, 0);
      expect_state(0, 16'h0081, 16'h0080, 16'h0081, 0, 1); tick();
      drive(0, 0, 0, 0, 0, 0);
      expect_state(0, 16'h0200, 16'h0081, 16'h0082, 0, 0); tick();

      // Equal level on release: live wins over pending
      drive(1, 1, 16'h0300, 0, 0, 0);
      expect_state(0, 16'h0200, 16'h0081, 16'h0082, 0, 1); tick();
      drive(0, 1, 16'h0400, 0, 0, 0);
      expect_state(0, 16'h0400, 16'h0200, 16'h0201, 0, 0); tick();

      // Reset mid-cycle with a pending redirect
      drive(1, 0, 0, 1, 16'h0500, 0);
      expect_state(0, 16'h0400, 16'h0200, 16'h0201, 0, 1); tick();
      #2;
      rst = 1'b1;
      #1;
      expect_state(0, 16'h0000, 16'h0000, 16'h0000, 0, 0); check_now();
      drive(0, 0, 0, 0, 0, 0);
      expect_state(0, 16'h0000, 16'h0000, 16'h0000, 0, 0); tick();
      rst = 1'b0;
      expect_state(0, 16'h0000, 16'h0000, 16'h0000, 0, 0); check_now();
      expect_state(0, 16'h0001, 16'h0000, 16'h0001, 1, 0); tick();

      // RESET_PC = FFFF wraps
      expect_state(1, 16'hFFFF, 16'h0000, 16'h0000, 0, 0); check_now();
      rst_b = 1'b0;
      expect_state(1, 16'h0000, 16'hFFFF, 16'h0000, 1, 0); tick();
      expect_state(1, 16'h0001, 16'h0000, 16'h0001, 1, 0); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
